// File: rtl/pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_fade_ctrl
//  Purpose  : Trigger-started brightness envelope (up, hold, down, off) that
//             feeds a pwm instance, with its own fade-step tick divider.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_fade_ctrl #(
    parameter int BITS       = 8,
    parameter int TICK_DIV   = 1024,
    parameter int HOLD_TICKS = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            trigger,
    input  logic            stop,
    input  logic [BITS-1:0] max_bright,
    input  logic [BITS-1:0] step,
    output logic [BITS-1:0] bright,
    output logic            busy,
    output logic            done
);

    localparam int c_TICK_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int c_HOLD_LOAD = (HOLD_TICKS < 1) ? 1 : HOLD_TICKS;
    localparam int c_HOLD_W    = $clog2(c_HOLD_LOAD + 1);

    localparam logic [c_TICK_W-1:0] c_TICK_RELOAD = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_RELOAD = c_HOLD_W'(c_HOLD_LOAD);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST   = c_HOLD_W'(1);
    localparam logic [BITS-1:0]     c_STEP_MIN    = BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_HOLD = 2'd2,
        S_DOWN = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BITS-1:0]     r_bright;
    logic [BITS-1:0]     w_bright_nxt;
    logic [BITS-1:0]     r_max;
    logic [BITS-1:0]     w_max_nxt;
    logic [BITS-1:0]     r_step;
    logic [BITS-1:0]     w_step_nxt;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [c_TICK_W-1:0] w_tick_cnt_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_tick_reload;

    logic                w_tick;
    logic [BITS:0]       w_sum;
    logic [BITS-1:0]     w_up_val;
    logic [BITS-1:0]     w_down_val;
    logic [BITS-1:0]     w_step_in;

    assign w_tick     = (r_state != S_IDLE) && (r_tick_cnt == '0);
    // Extra carry bit keeps the ramp from wrapping past the peak.
    assign w_sum      = {1'b0, r_bright} + {1'b0, r_step};
    assign w_up_val   = (w_sum > {1'b0, r_max}) ? r_max : w_sum[BITS-1:0];
    assign w_down_val = (r_bright > r_step) ? (r_bright - r_step) : '0;
    assign w_step_in  = (step == '0) ? c_STEP_MIN : step;

    always_comb begin
        w_state_nxt   = r_state;
        w_bright_nxt  = r_bright;
        w_max_nxt     = r_max;
        w_step_nxt    = r_step;
        w_hold_nxt    = r_hold;
        w_done_nxt    = 1'b0;
        w_tick_reload = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (trigger) begin
                    w_max_nxt     = max_bright;
                    w_step_nxt    = w_step_in;
                    w_tick_reload = 1'b1;
                    w_state_nxt   = S_UP;
                end
            end
            S_UP: begin
                if (w_tick) begin
                    w_bright_nxt = w_up_val;
                end
                if (stop) begin
                    w_state_nxt = S_DOWN;
                end else if (w_tick && (w_up_val == r_max)) begin
                    w_hold_nxt  = c_HOLD_RELOAD;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (stop) begin
                    w_state_nxt = S_DOWN;
                end else if (trigger) begin
                    w_hold_nxt    = c_HOLD_RELOAD;
                    w_tick_reload = 1'b1;
                end else if (w_tick) begin
                    if (r_hold <= c_HOLD_LAST) begin
                        // A zero peak has nothing to ramp down, so the hold
                        // expiry tick doubles as the final down tick.
                        if (r_bright == '0) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_DOWN;
                        end
                    end else begin
                        w_hold_nxt = r_hold - c_HOLD_LAST;
                    end
                end
            end
            S_DOWN: begin
                if (w_tick) begin
                    w_bright_nxt = w_down_val;
                end
                if (trigger) begin
                    w_max_nxt     = max_bright;
                    w_step_nxt    = w_step_in;
                    w_tick_reload = 1'b1;
                    w_state_nxt   = S_UP;
                end else if (w_tick && (w_down_val == '0)) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_tick_cnt_nxt = r_tick_cnt;
        if (w_tick_reload) begin
            w_tick_cnt_nxt = c_TICK_RELOAD;
        end else if (r_state != S_IDLE) begin
            w_tick_cnt_nxt = (r_tick_cnt == '0) ? c_TICK_RELOAD : (r_tick_cnt - 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_bright   <= '0;
            r_max      <= '0;
            r_step     <= '0;
            r_hold     <= '0;
            r_tick_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bright   <= w_bright_nxt;
            r_max      <= w_max_nxt;
            r_step     <= w_step_nxt;
            r_hold     <= w_hold_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign bright = r_bright;
    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;

endmodule
`default_nettype wire
